// File: rtl/writeback_regfile.sv
// Writeback stage result select feeding a 31-entry register file.
// Two async read ports with same-cycle write-through bypass; x0 reads zero.
module writeback_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [XLEN-1:0]          ALUResultW,
  input  logic [XLEN-1:0]          ReadDataW,
  input  logic [XLEN-1:0]          PCPlus4W,
  input  logic [1:0]               ResultSrcW,
  input  logic [$clog2(NREGS)-1:0] RdW,
  input  logic                     RegWriteW,
  input  logic [$clog2(NREGS)-1:0] A1,
  input  logic [$clog2(NREGS)-1:0] A2,
  output logic [XLEN-1:0]          RD1,
  output logic [XLEN-1:0]          RD2,
  output logic [XLEN-1:0]          ResultW
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0] r_regs [1:NREGS-1];

  logic            w_we;
  logic            w_byp1;
  logic            w_byp2;
  logic [XLEN-1:0] w_rd1;
  logic [XLEN-1:0] w_rd2;

  always_comb begin
    ResultW = '0;
    unique case (ResultSrcW)
      2'b00: ResultW = ALUResultW;
      2'b01: ResultW = ReadDataW;
      2'b10: ResultW = PCPlus4W;
      2'b11: ResultW = '0;
    endcase
  end

  // Reset wins over any concurrent write and also kills the bypass.
  assign w_we = RegWriteW & ~rst & (RdW != AW'(0));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREGS; i++)
        r_regs[i] <= '0;
    end else if (w_we) begin
      r_regs[RdW] <= ResultW;
    end
  end

  assign w_rd1 = (A1 == AW'(0)) ? '0 : r_regs[A1];
  assign w_rd2 = (A2 == AW'(0)) ? '0 : r_regs[A2];

  assign w_byp1 = w_we & (A1 == RdW);
  assign w_byp2 = w_we & (A2 == RdW);

  assign RD1 = w_byp1 ? ResultW : w_rd1;
  assign RD2 = w_byp2 ? ResultW : w_rd2;

endmodule

// File: tb/tb_writeback_regfile.sv
// Randomized bench for writeback_regfile against an array-based model.
// Directed cases cover reset, bypass, x0, result select and full sweep.
module tb_writeback_regfile;

  logic        clk;
  logic        rst;
  logic [31:0] ALUResultW;
  logic [31:0] ReadDataW;
  logic [31:0] PCPlus4W;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RdW;
  logic        RegWriteW;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic [31:0] ResultW;

  int n_err = 0;
  int n_chk = 0;

  logic [31:0] model [0:31];

  writeback_regfile #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk),
    .rst(rst),
    .ALUResultW(ALUResultW),
    .ReadDataW(ReadDataW),
    .PCPlus4W(PCPlus4W),
    .ResultSrcW(ResultSrcW),
    .RdW(RdW),
    .RegWriteW(RegWriteW),
    .A1(A1),
    .A2(A2),
    .RD1(RD1),
    .RD2(RD2),
    .ResultW(ResultW)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_result();
    logic [31:0] opts [4];
    opts[0] = ALUResultW;
    opts[1] = ReadDataW;
    opts[2] = PCPlus4W;
    opts[3] = 32'd0;
    return opts[ResultSrcW];
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (RegWriteW && !rst && RdW != 0 && a == RdW)
      return exp_result();
    return model[a];
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".res"}, ResultW, exp_result());
    chk({tag, ".rd1"}, RD1, exp_rd(A1));
    chk({tag, ".rd2"}, RD2, exp_rd(A2));
  endtask

  // Inputs are stable when called; advance one edge and update the model.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
    end else if (RegWriteW && RdW != 0) begin
      model[RdW] = exp_result();
    end
    #1;
  endtask

  task automatic idle();
    rst = 0; RegWriteW = 0; RdW = 0; ResultSrcW = 0;
    ALUResultW = 0; ReadDataW = 0; PCPlus4W = 0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    idle();
    A1 = 0; A2 = 0;
    #2;
    rst = 1;
    tick();
    rst = 0;

    A1 = 5; A2 = 31; #1;
    chk("rst.rd1", RD1, 32'd0);
    chk("rst.rd2", RD2, 32'd0);

    RegWriteW = 1; RdW = 3; ResultSrcW = 2'b00;
    ALUResultW = 32'h1234_5678; A1 = 3; #1;
    chk("byp.rd1", RD1, 32'h1234_5678);
    tick();
    RegWriteW = 0; #1;
    chk("stor.rd1", RD1, 32'h1234_5678);

    RegWriteW = 1; RdW = 0; ALUResultW = 32'hFFFF_FFFF;
    A1 = 0; A2 = 0; #1;
    chk("x0w.rd1", RD1, 32'd0);
    chk("x0w.rd2", RD2, 32'd0);
    tick();
    RegWriteW = 0; #1;
    chk("x0a.rd1", RD1, 32'd0);
    chk("x0a.rd2", RD2, 32'd0);

    ALUResultW = 32'hA; ReadDataW = 32'hB; PCPlus4W = 32'hC;
    RegWriteW = 1; RdW = 7; A1 = 1; A2 = 2;
    for (int s = 0; s < 4; s++) begin
      logic [31:0] want [4];
      want[0] = 32'hA; want[1] = 32'hB;
      want[2] = 32'hC; want[3] = 32'h0;
      ResultSrcW = 2'(s); #1;
      chk("sel", ResultW, want[s]);
      tick();
    end
    RegWriteW = 0; A1 = 7; #1;
    chk("x7.end", RD1, 32'd0);

    RegWriteW = 1; RdW = 9; ResultSrcW = 0; ALUResultW = 32'hDEAD_BEEF;
    tick();
    rst = 1; ALUResultW = 32'h1; A1 = 9; #1;
    chk("rstbyp.rd1", RD1, 32'hDEAD_BEEF);
    chk("rstbyp.res", ResultW, 32'h1);
    tick();
    rst = 0; RegWriteW = 0; #1;
    chk("rstw.x9", RD1, 32'd0);

    RegWriteW = 1; ResultSrcW = 0;
    for (int i = 1; i < 32; i++) begin
      RdW = 5'(i); ALUResultW = 32'(i);
      tick();
    end
    RegWriteW = 0;
    for (int i = 1; i < 32; i++) begin
      A1 = 5'(i); A2 = 5'(32 - i); #1;
      chk("sweep.rd1", RD1, 32'(i));
      chk("sweep.rd2", RD2, 32'(32 - i));
    end
    RegWriteW = 1; RdW = 12; A1 = 12; A2 = 12; ALUResultW = 32'h55; #1;
    chk("dual.rd1", RD1, 32'h55);
    chk("dual.rd2", RD2, 32'h55);
    tick();

    for (int n = 0; n < 500; n++) begin
      rst        = ($urandom_range(0, 40) == 0);
      RegWriteW  = 1'($urandom);
      RdW        = 5'($urandom);
      ResultSrcW = 2'($urandom);
      ALUResultW = $urandom;
      ReadDataW  = $urandom;
      PCPlus4W   = $urandom;
      A1 = ($urandom_range(0, 3) == 0) ? RdW : 5'($urandom);
      A2 = ($urandom_range(0, 3) == 0) ? RdW : 5'($urandom);
      #1;
      check_all("rnd");
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning datapath width in bits.
REQ-002 The block SHALL have parameter NREGS, default 32, meaning architectural register count (address width 5).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port ALUResultW, input, 32, W-stage ALU result.
REQ-006 The block SHALL have port ReadDataW, input, 32, W-stage load data.
REQ-007 The block SHALL have port PCPlus4W, input, 32, W-stage link address.
REQ-008 The block SHALL have port ResultSrcW, input, 2, result select.
REQ-009 The block SHALL have port RdW, input, 5, destination register.
REQ-010 The block SHALL have port RegWriteW, input, 1, write enable.
REQ-011 The block SHALL have ports A1 and A2, input, 5 each, D-stage source register addresses.
REQ-012 The block SHALL have ports RD1 and RD2, output, 32 each, source operand data.
REQ-013 The block SHALL have port ResultW, output, 32, selected writeback value, also fed to forwarding.

Function
REQ-014 ResultW SHALL be combinational: ResultSrcW 00 -> ALUResultW, 01 -> ReadDataW, 10 -> PCPlus4W, 11 -> 32'd0.
REQ-015 Storage SHALL be 31 registers x1..x31 of 32 bits; x0 SHALL NOT be storage.
REQ-016 On a rising clk with rst=0, RegWriteW=1 and RdW!=0, register RdW SHALL take ResultW; otherwise all registers SHALL hold.
REQ-017 A write with RdW=0 SHALL be discarded; RD1/RD2 for address 0 SHALL always be 32'd0.
REQ-018 RD1 and RD2 SHALL be asynchronous reads of the addressed register (zero-cycle read latency).
REQ-019 Write-through bypass: when RegWriteW=1, RdW!=0 and A1==RdW, RD1 SHALL equal ResultW in that same cycle; likewise RD2 for A2.
REQ-020 The bypass SHALL apply independently to both ports, including A1==A2==RdW.
REQ-021 Bypass SHALL be suppressed when rst=1 (reads return register contents, i.e. 0 after that edge semantics per REQ-023).
REQ-022 Write-to-register latency SHALL be one clock: value visible from storage the cycle after the write edge, from bypass in the write cycle.

Reset
REQ-023 On a rising clk with rst=1, all registers x1..x31 SHALL become 32'd0, and any concurrent write SHALL be discarded.
REQ-024 Reset asserted mid-sequence SHALL override pending writes; the first write after deassertion SHALL behave per REQ-016.
REQ-025 ResultW SHALL remain a pure function of its inputs during reset; RD1/RD2 SHALL read 32'd0 for every address from the cycle after the reset edge until written.

Verification
REQ-026 rst=1 for one edge, then read A1=5, A2=31 -> RD1=RD2=32'd0.
REQ-027 RegWriteW=1, RdW=3, ResultSrcW=00, ALUResultW=32'h1234_5678, A1=3 same cycle -> RD1=32'h1234_5678 (bypass); next cycle with RegWriteW=0 -> RD1 still 32'h1234_5678.
REQ-028 RegWriteW=1, RdW=0, ALUResultW=32'hFFFF_FFFF, A1=A2=0 -> RD1=RD2=0 in write cycle and after.
REQ-029 Sweep ResultSrcW 00/01/10/11 with ALUResultW=32'hA, ReadDataW=32'hB, PCPlus4W=32'hC -> ResultW = A, B, C, 0; write RdW=7 each edge -> x7 ends 0.
REQ-030 Write x9=32'hDEAD_BEEF, then same edge rst=1 and RegWriteW=1, RdW=9, ALUResultW=32'h1 -> x9 reads 0 afterwards.
REQ-031 Write all x1..x31 with value=index, then read all pairs (A1=i, A2=32-i) -> RD1=i, RD2=32-i; A1=A2=RdW=12 during write of 32'h55 -> both read 32'h55.
